operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable samples required to accept a key level change (10 ms at 50 MHz).
REQ-002 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port sw, input, 4: raw slide-switch nibble, sampled at capture time.
REQ-005 Port key_enter_n, input, 1: raw pushbutton, active-low, asynchronous to clk, bouncing.
REQ-006 Port key_clear_n, input, 1: raw pushbutton, active-low, asynchronous to clk, bouncing.
REQ-007 Port z, output, 8: operand bus to the arithmetic stage, with x in z[3:0] and y in z[7:4].
REQ-008 Port select, output, 2: operation code to the arithmetic stage.
REQ-009 Port ready, output, 1: high when x, y and select are all loaded and stable.
REQ-010 Port phase, output, 2: current FSM state encoding, for the status LEDs.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer followed by a debouncer.
- The debouncer's accepted level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current accepted level.
- Any sample equal to the accepted level SHALL reset the debounce counter to 0.
REQ-012 A press event SHALL be a single-cycle pulse, asserted in the cycle after a key's accepted level goes 1->0.
- Release (0->1) SHALL generate no event.
- Holding a key SHALL generate exactly one event.
REQ-013 The latency from a stable raw low level to the press pulse SHALL be DEBOUNCE_CYCLES+3 clk cycles, with ±1 cycle allowed for synchronizer alignment.
REQ-014 The FSM SHALL have four states with phase encodings: LOAD_X=00, LOAD_Y=01, LOAD_OP=10, READY=11.
REQ-015 LOAD_X on an enter event: z[3:0] <= sw, then go to LOAD_Y.
REQ-016 LOAD_Y on an enter event: z[7:4] <= sw, then go to LOAD_OP.
REQ-017 LOAD_OP on an enter event: select <= sw[1:0], then go to READY.
- ready SHALL rise in the same cycle that select updates.
REQ-018 READY on an enter event: ready <= 0, go to LOAD_X.
- z and select SHALL retain their values until they are overwritten by a later capture.
REQ-019 A clear event in any state SHALL set z=0, select=0, ready=0 and go to LOAD_X.
REQ-020 When clear and enter events occur in the same cycle, clear SHALL take priority and the enter event SHALL be discarded.
REQ-021 All outputs SHALL be driven directly from registers, with no combinational path from sw or the keys to any output.
REQ-022 sw SHALL be sampled only in the capture cycle; changes to sw at any other time SHALL have no effect on the outputs.

Reset
REQ-023 While reset_n=0, the outputs SHALL be z=0, select=0, ready=0, phase=00.
- The synchronizer flops and accepted key levels SHALL reset to 1 (released).
- The debounce counters SHALL reset to 0.
REQ-024 Reset assertion mid-debounce or mid-entry SHALL abandon the operation, and no event SHALL fire after reset_n deasserts unless a fresh stable press occurs.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Full entry sequence:
- Stimulus: enter presses with sw=3, then 5, then 2.
- Required: z=8'h53, select=2'b10, ready=1, phase=11.
REQ-026 Bounce rejection:
- Stimulus: key_enter_n toggles every 2 cycles for 20 cycles, then holds low for 10 cycles.
- Required: exactly one capture, and phase advances by one state.
REQ-027 Simultaneous clear and enter:
- Stimulus: clear and enter events in the same cycle while in LOAD_OP with z=8'h53.
- Required: z=0, select=0, phase=00, ready=0.
REQ-028 Wrap from READY:
- Stimulus: in READY with z=8'h53, one enter event, then an enter event with sw=F.
- Required: after the first event, ready=0, phase=00, z still 8'h53; after the second, z=8'h5F.
REQ-029 Asynchronous reset:
- Stimulus: reset_n pulsed low for less than one clk period, between clock edges, during LOAD_Y.
- Required: the outputs clear immediately without waiting for a clock edge, and phase=00 after the pulse.
REQ-030 Held key:
- Stimulus: enter held low for 100 cycles.
- Required: exactly one phase transition, and no further event until release plus a new press.

Source files
------------

// File: rtl/operand_loader.sv
// Operand entry front end: debounces two pushbuttons and steps a four-state
// loader that captures x, y and an operation code from the slide switches.
module operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    output logic [7:0] z,
    output logic [1:0] select,
    output logic       ready,
    output logic [1:0] phase
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] LOAD_X  = 2'b00;
    localparam logic [1:0] LOAD_Y  = 2'b01;
    localparam logic [1:0] LOAD_OP = 2'b10;
    localparam logic [1:0] READY   = 2'b11;

    // Key index 0 is enter, index 1 is clear; all key levels are active-low.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       press_q, press_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0] state_q, state_d;
    logic [7:0] z_q, z_d;
    logic [1:0] select_q, select_d;
    logic       ready_q, ready_d;

    // Synchronizer, debounce counter and falling-edge press detection.
    always_comb begin
        sync1_d = {key_clear_n, key_enter_n};
        sync2_d = sync1_q;
        level_d = level_q;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != level_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        press_d = level_q & ~level_d;
    end

    // Loader FSM; a clear event outranks an enter event in the same cycle.
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        select_d = select_q;
        ready_d  = ready_q;
        if (press_q[1]) begin
            state_d  = LOAD_X;
            z_d      = '0;
            select_d = '0;
            ready_d  = 1'b0;
        end else if (press_q[0]) begin
            case (state_q)
                LOAD_X: begin
                    z_d[3:0] = sw;
                    state_d  = LOAD_Y;
                end
                LOAD_Y: begin
                    z_d[7:4] = sw;
                    state_d  = LOAD_OP;
                end
                LOAD_OP: begin
                    select_d = sw[1:0];
                    ready_d  = 1'b1;
                    state_d  = READY;
                end
                default: begin
                    ready_d = 1'b0;
                    state_d = LOAD_X;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            level_q  <= 2'b11;
            press_q  <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            state_q  <= LOAD_X;
            z_q      <= '0;
            select_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            press_q  <= press_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            state_q  <= state_d;
            z_q      <= z_d;
            select_q <= select_d;
            ready_q  <= ready_d;
        end
    end

    assign z      = z_q;
    assign select = select_q;
    assign ready  = ready_q;
    assign phase  = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed plus randomized bench for operand_loader with a short debounce
// window, checked against an event-level model of the loader.
module tb_operand_loader;

    logic       clk;
    logic       reset_n;
    logic [3:0] sw;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [7:0] z;
    logic [1:0] select;
    logic       ready;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    int trans  = 0;
    logic [1:0] phase_prev = 2'b00;

    // Event-level model state
    logic [3:0] mx, my;
    logic [1:0] msel;
    logic       mrdy;
    int         mph;

    operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw          (sw),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .z           (z),
        .select      (select),
        .ready       (ready),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (phase !== phase_prev) trans = trans + 1;
        phase_prev = phase;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mx = 0; my = 0; msel = 0; mrdy = 0; mph = 0;
    endtask

    task automatic model_enter(input logic [3:0] s);
        if (mph == 0) mx = s;
        else if (mph == 1) my = s;
        else if (mph == 2) begin msel = s[1:0]; mrdy = 1; end
        else mrdy = 0;
        mph = (mph + 1) % 4;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".z"},      32'(z),      32'({my, mx}));
        chk({tag, ".select"}, 32'(select), 32'(msel));
        chk({tag, ".ready"},  32'(ready),  32'(mrdy));
        chk({tag, ".phase"},  32'(phase),  32'(mph));
    endtask

    // Stable press long enough to pass debounce, then release with sw scrambled.
    task automatic press(input logic en, input logic cl, input logic [3:0] s);
        sw = s;
        if (en) key_enter_n = 1'b0;
        if (cl) key_clear_n = 1'b0;
        tick(12);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw = 4'($urandom);
        tick(12);
        if (cl) model_clear();
        else if (en) model_enter(s);
    endtask

    initial begin
        int t0;
        logic [3:0] s;
        reset_n = 1'b0; sw = 4'h0; key_enter_n = 1'b1; key_clear_n = 1'b1;
        model_clear();
        tick(3);
        check_all("reset");
        reset_n = 1'b1;
        tick(2);

        // Full entry sequence
        press(1, 0, 4'h3);
        press(1, 0, 4'h5);
        press(1, 0, 4'h2);
        check_all("entry");
        chk("entry.z53", 32'(z), 32'h53);

        // Wrap from READY keeps operands until overwritten
        press(1, 0, 4'($urandom));
        check_all("wrap1");
        chk("wrap1.z53", 32'(z), 32'h53);
        press(1, 0, 4'hF);
        chk("wrap2.z5f", 32'(z), 32'h5F);

        // Randomized mix of enter and clear events
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 4) == 0) press(0, 1, 4'($urandom));
            else press(1, 0, 4'($urandom));
            check_all($sformatf("rand%0d", i));
        end

        // Simultaneous clear and enter in LOAD_OP with z=53
        press(0, 1, 4'h0);
        press(1, 0, 4'h3);
        press(1, 0, 4'h5);
        chk("simul.pre", 32'(phase), 32'h2);
        press(1, 1, 4'($urandom));
        check_all("simul");

        // Bounce rejection
        t0 = trans;
        s = 4'($urandom);
        sw = s;
        for (int i = 0; i < 10; i++) begin
            key_enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_enter_n = 1'b0;
        tick(10);
        key_enter_n = 1'b1;
        sw = 4'($urandom);
        tick(12);
        model_enter(s);
        chk("bounce.trans", 32'(trans - t0), 32'd1);
        check_all("bounce");

        // Held key produces a single event
        t0 = trans;
        s = 4'($urandom);
        sw = s;
        key_enter_n = 1'b0;
        tick(100);
        chk("held.trans", 32'(trans - t0), 32'd1);
        key_enter_n = 1'b1;
        sw = 4'($urandom);
        tick(12);
        chk("held.release", 32'(trans - t0), 32'd1);
        model_enter(s);
        check_all("held");
        press(1, 0, 4'($urandom));
        chk("held.repress", 32'(trans - t0), 32'd2);

        // Short asynchronous reset pulse during LOAD_Y
        press(0, 1, 4'h0);
        press(1, 0, 4'(1 + $urandom_range(0, 14)));
        chk("areset.pre", 32'(phase), 32'h1);
        tick(1);
        #3 reset_n = 1'b0;
        #1;
        chk("areset.z",      32'(z),      32'h0);
        chk("areset.select", 32'(select), 32'h0);
        chk("areset.ready",  32'(ready),  32'h0);
        chk("areset.phase",  32'(phase),  32'h0);
        #2 reset_n = 1'b1;
        tick(2);
        model_clear();
        check_all("areset.post");

        // Reset mid-debounce abandons the pending press
        t0 = trans;
        key_enter_n = 1'b0;
        tick(4);
        #2 reset_n = 1'b0;
        key_enter_n = 1'b1;
        #2 reset_n = 1'b1;
        tick(20);
        chk("middeb.trans", 32'(trans - t0), 32'd0);
        check_all("middeb");
        press(1, 0, 4'h7);
        check_all("middeb.fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
